// File: rtl/nasti_burst_split_if.sv
// nasti_channel: NASTI five-channel bundle with master/slave views.
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;
    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/nasti_burst_split.sv
// nasti_burst_split: splits NASTI bursts longer than MAX_BEATS into back-to-back sub-bursts.
// Define NASTI_BURST_SPLIT_RESP_MERGE_EN to return the worst B response over all sub-bursts.
module nasti_burst_split #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BEATS  = 16
) (
    input logic          clk,
    input logic          rstn,
    nasti_channel.slave  s,
    nasti_channel.master m
);
    localparam logic [8:0] MAXB = 9'(MAX_BEATS);
    localparam logic [1:0] INCR = 2'b01;
    localparam logic [2:0] W_IDLE = 3'd0, W_ADDR = 3'd1, W_DATA = 3'd2, W_RESP = 3'd3, W_BRSP = 3'd4;
    localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;

    // Sub-bursts are MAX_BEATS-aligned slices of the original, so no new 4KB crossing can appear.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size, input logic [1:0] burst);
        return burst == INCR ? a + (ADDR_WIDTH'(MAX_BEATS) << size) : a;
    endfunction

    logic [2:0]            w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_lock;
    logic [3:0]            w_cache;
    logic [2:0]            w_prot;
    logic [3:0]            w_qos;
    logic [3:0]            w_region;
    logic [USER_WIDTH-1:0] w_user;
    logic [8:0]            w_rem;
    logic [8:0]            w_sub;
    logic [7:0]            w_cnt;
    logic [7:0]            w_sub_len;
    logic [1:0]            b_resp;
    logic [USER_WIDTH-1:0] b_user;
    logic                  w_go;
    logic                  w_end;

    assign w_sub     = w_rem > MAXB ? MAXB : w_rem;
    assign w_sub_len = 8'(w_sub - 9'd1);
    assign w_end     = w_cnt == w_sub_len;
    assign w_go      = w_state == W_DATA && s.w_valid && m.w_ready;

    assign s.aw_ready  = w_state == W_IDLE;
    assign m.aw_valid  = w_state == W_ADDR;
    assign m.aw_id     = w_id;
    assign m.aw_addr   = w_addr;
    assign m.aw_len    = w_sub_len;
    assign m.aw_size   = w_size;
    assign m.aw_burst  = w_burst;
    assign m.aw_lock   = w_lock;
    assign m.aw_cache  = w_cache;
    assign m.aw_prot   = w_prot;
    assign m.aw_qos    = w_qos;
    assign m.aw_region = w_region;
    assign m.aw_user   = w_user;
    assign m.w_valid   = w_state == W_DATA && s.w_valid;
    assign s.w_ready   = w_state == W_DATA && m.w_ready;
    assign m.w_data    = s.w_data;
    assign m.w_strb    = s.w_strb;
    assign m.w_user    = s.w_user;
    assign m.w_last    = w_end;
    assign m.b_ready   = w_state == W_RESP;
    assign s.b_valid   = w_state == W_BRSP;
    assign s.b_id      = w_id;
    assign s.b_resp    = b_resp;
    assign s.b_user    = b_user;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_addr   <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_lock   <= 1'b0;
            w_cache  <= '0;
            w_prot   <= '0;
            w_qos    <= '0;
            w_region <= '0;
            w_user   <= '0;
            w_rem    <= '0;
            w_cnt    <= '0;
            b_resp   <= '0;
            b_user   <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (s.aw_valid) begin
                    w_id     <= s.aw_id;
                    w_addr   <= s.aw_addr;
                    w_size   <= s.aw_size;
                    w_burst  <= s.aw_burst;
                    w_lock   <= s.aw_lock;
                    w_cache  <= s.aw_cache;
                    w_prot   <= s.aw_prot;
                    w_qos    <= s.aw_qos;
                    w_region <= s.aw_region;
                    w_user   <= s.aw_user;
                    w_rem    <= 9'(s.aw_len) + 9'd1;
                    w_cnt    <= '0;
                    b_resp   <= '0;
                    w_state  <= W_ADDR;
                end
                W_ADDR: if (m.aw_ready) w_state <= W_DATA;
                W_DATA: if (w_go) begin
                    w_cnt <= w_end ? 8'd0 : w_cnt + 8'd1;
                    if (w_end) begin
                        w_rem   <= w_rem - w_sub;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (m.b_valid) begin
                    b_user <= m.b_user;
`ifdef NASTI_BURST_SPLIT_RESP_MERGE_EN
                    b_resp <= m.b_resp > b_resp ? m.b_resp : b_resp;
`else
                    b_resp <= m.b_resp;
`endif
                    w_addr  <= w_rem != 9'd0 ? next_addr(w_addr, w_size, w_burst) : w_addr;
                    w_state <= w_rem != 9'd0 ? W_ADDR : W_BRSP;
                end
                W_BRSP: if (s.b_ready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    logic [1:0]            r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_lock;
    logic [3:0]            r_cache;
    logic [2:0]            r_prot;
    logic [3:0]            r_qos;
    logic [3:0]            r_region;
    logic [USER_WIDTH-1:0] r_user;
    logic [8:0]            r_rem;
    logic [8:0]            r_sub;
    logic                  r_end;

    assign r_sub = r_rem > MAXB ? MAXB : r_rem;
    assign r_end = r_state == R_DATA && m.r_valid && s.r_ready && m.r_last;

    assign s.ar_ready  = r_state == R_IDLE;
    assign m.ar_valid  = r_state == R_ADDR;
    assign m.ar_id     = r_id;
    assign m.ar_addr   = r_addr;
    assign m.ar_len    = 8'(r_sub - 9'd1);
    assign m.ar_size   = r_size;
    assign m.ar_burst  = r_burst;
    assign m.ar_lock   = r_lock;
    assign m.ar_cache  = r_cache;
    assign m.ar_prot   = r_prot;
    assign m.ar_qos    = r_qos;
    assign m.ar_region = r_region;
    assign m.ar_user   = r_user;
    assign s.r_valid   = r_state == R_DATA && m.r_valid;
    assign m.r_ready   = r_state == R_DATA && s.r_ready;
    assign s.r_id      = m.r_id;
    assign s.r_data    = m.r_data;
    assign s.r_resp    = m.r_resp;
    assign s.r_user    = m.r_user;
    assign s.r_last    = m.r_last && r_rem == r_sub;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_lock   <= 1'b0;
            r_cache  <= '0;
            r_prot   <= '0;
            r_qos    <= '0;
            r_region <= '0;
            r_user   <= '0;
            r_rem    <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (s.ar_valid) begin
                    r_id     <= s.ar_id;
                    r_addr   <= s.ar_addr;
                    r_size   <= s.ar_size;
                    r_burst  <= s.ar_burst;
                    r_lock   <= s.ar_lock;
                    r_cache  <= s.ar_cache;
                    r_prot   <= s.ar_prot;
                    r_qos    <= s.ar_qos;
                    r_region <= s.ar_region;
                    r_user   <= s.ar_user;
                    r_rem    <= 9'(s.ar_len) + 9'd1;
                    r_state  <= R_ADDR;
                end
                R_ADDR: if (m.ar_ready) r_state <= R_DATA;
                R_DATA: if (r_end) begin
                    r_rem   <= r_rem - r_sub;
                    r_addr  <= next_addr(r_addr, r_size, r_burst);
                    r_state <= r_rem == r_sub ? R_IDLE : R_ADDR;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nasti_burst_split.sv
// tb_nasti_burst_split: directed checks of sub-burst splitting, B merging and mid-burst reset.
module tb_nasti_burst_split;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int total = 0;
    int passed = 0;
    logic [15:0] a_log[$];
    int l_log[$];
    int last_log[$];
    int nbeats, nb, b_lat, rbad, g;
    logic [1:0] b_resp_seen;
    logic b_id_seen, b_user_seen, early_wr;
    logic [9:0] aw_attr;

    nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(16), .DATA_WIDTH(8), .USER_WIDTH(1)) s_bus ();
    nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(16), .DATA_WIDTH(8), .USER_WIDTH(1)) m_bus ();

    nasti_burst_split #(.ID_WIDTH(1), .ADDR_WIDTH(16), .DATA_WIDTH(8), .USER_WIDTH(1), .MAX_BEATS(16)) dut (
        .clk(clk),
        .rstn(rstn),
        .s(s_bus),
        .m(m_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic init_bus;
        s_bus.aw_id = 0; s_bus.aw_addr = 0; s_bus.aw_len = 0; s_bus.aw_size = 0; s_bus.aw_burst = 0;
        s_bus.aw_lock = 0; s_bus.aw_cache = 0; s_bus.aw_prot = 0; s_bus.aw_qos = 0; s_bus.aw_region = 0;
        s_bus.aw_user = 0; s_bus.aw_valid = 0;
        s_bus.w_data = 0; s_bus.w_strb = 1; s_bus.w_last = 0; s_bus.w_user = 0; s_bus.w_valid = 0;
        s_bus.b_ready = 0;
        s_bus.ar_id = 0; s_bus.ar_addr = 0; s_bus.ar_len = 0; s_bus.ar_size = 0; s_bus.ar_burst = 0;
        s_bus.ar_lock = 0; s_bus.ar_cache = 0; s_bus.ar_prot = 0; s_bus.ar_qos = 0; s_bus.ar_region = 0;
        s_bus.ar_user = 0; s_bus.ar_valid = 0; s_bus.r_ready = 0;
        m_bus.aw_ready = 0; m_bus.w_ready = 0;
        m_bus.b_id = 0; m_bus.b_resp = 0; m_bus.b_user = 0; m_bus.b_valid = 0;
        m_bus.ar_ready = 0;
        m_bus.r_id = 0; m_bus.r_data = 0; m_bus.r_resp = 0; m_bus.r_last = 0; m_bus.r_user = 0; m_bus.r_valid = 0;
    endtask

    // Upstream master plus an always-ready downstream slave; sub-burst 0 answers r0, later ones r1.
    task automatic write_burst(input logic [15:0] addr, input logic [1:0] burst, input logic [7:0] len,
                               input logic [1:0] r0, input logic [1:0] r1);
        int beat, sub, w;
        logic lst;
        beat = 0; sub = 0;
        a_log.delete(); l_log.delete(); last_log.delete(); nb = 0;
        s_bus.aw_id = 1'b1; s_bus.aw_addr = addr; s_bus.aw_len = len; s_bus.aw_size = 3'd2;
        s_bus.aw_burst = burst; s_bus.aw_cache = 4'h3; s_bus.aw_valid = 1'b1;
        s_bus.w_valid = 1'b1; m_bus.w_ready = 1'b1;
        w = 0; while (!s_bus.aw_ready && w < 20) begin tick; w++; end
        tick;
        s_bus.aw_valid = 1'b0;
        while (beat <= int'(len) && sub < 20) begin
            w = 0; while (!m_bus.aw_valid && w < 20) begin tick; w++; end
            if (sub == 0) begin
                early_wr = s_bus.w_ready;
                aw_attr = {m_bus.aw_size, m_bus.aw_burst, m_bus.aw_cache, m_bus.aw_id};
            end
            a_log.push_back(m_bus.aw_addr);
            l_log.push_back(int'(m_bus.aw_len));
            m_bus.aw_ready = 1'b1;
            tick;
            m_bus.aw_ready = 1'b0;
            w = 0;
            do begin
                s_bus.w_data = 8'(beat);
                #1;
                lst = m_bus.w_last;
                if (lst) last_log.push_back(beat);
                tick;
                beat++; w++;
            end while (!lst && w < 300);
            m_bus.b_valid = 1'b1; m_bus.b_resp = sub == 0 ? r0 : r1; m_bus.b_user = 1'(sub);
            w = 0; while (!m_bus.b_ready && w < 20) begin tick; w++; end
            tick;
            m_bus.b_valid = 1'b0;
            sub++;
        end
        s_bus.w_valid = 1'b0; m_bus.w_ready = 1'b0;
        w = 0; while (!s_bus.b_valid && w < 20) begin tick; w++; end
        b_lat = w; b_resp_seen = s_bus.b_resp; b_id_seen = s_bus.b_id; b_user_seen = s_bus.b_user;
        s_bus.b_ready = 1'b1;
        tick;
        s_bus.b_ready = 1'b0;
        repeat (3) begin if (s_bus.b_valid) nb++; tick; end
    endtask

    // Downstream slave ends each sub-burst on the ar_len it was given.
    task automatic read_burst(input logic [15:0] addr, input logic [7:0] len);
        int beat, sub, sl, w;
        beat = 0; sub = 0;
        a_log.delete(); l_log.delete(); last_log.delete(); nbeats = 0; rbad = 0;
        s_bus.ar_addr = addr; s_bus.ar_len = len; s_bus.ar_size = 3'd2; s_bus.ar_burst = 2'b01; s_bus.ar_valid = 1'b1;
        w = 0; while (!s_bus.ar_ready && w < 20) begin tick; w++; end
        tick;
        s_bus.ar_valid = 1'b0;
        s_bus.r_ready = 1'b1;
        while (beat <= int'(len) && sub < 20) begin
            w = 0; while (!m_bus.ar_valid && w < 20) begin tick; w++; end
            a_log.push_back(m_bus.ar_addr);
            l_log.push_back(int'(m_bus.ar_len));
            sl = int'(m_bus.ar_len);
            m_bus.ar_ready = 1'b1;
            tick;
            m_bus.ar_ready = 1'b0;
            for (int k = 0; k <= sl; k++) begin
                m_bus.r_valid = 1'b1; m_bus.r_data = 8'(beat); m_bus.r_last = k == sl;
                #1;
                if (s_bus.r_valid) nbeats++;
                if (s_bus.r_valid && s_bus.r_data !== 8'(beat)) rbad++;
                if (s_bus.r_valid && s_bus.r_last) last_log.push_back(beat);
                tick;
                beat++;
            end
            m_bus.r_valid = 1'b0; m_bus.r_last = 1'b0;
            sub++;
        end
        s_bus.r_ready = 1'b0;
    endtask

    initial begin
        init_bus;
        repeat (2) @(negedge clk);
        chk("reset_valids", {m_bus.aw_valid, m_bus.ar_valid, m_bus.w_valid, s_bus.b_valid, s_bus.r_valid}, 0);
        chk("reset_ready", {s_bus.aw_ready, s_bus.ar_ready}, 2'b11);
        rstn = 1'b1;
        tick;

        write_burst(16'h1000, 2'b01, 8'd39, 2'd0, 2'd0);
        chk("w40_nsub", a_log.size(), 3);
        chk("w40_addr0", a_log[0], 16'h1000);
        chk("w40_addr1", a_log[1], 16'h1040);
        chk("w40_addr2", a_log[2], 16'h1080);
        chk("w40_lens", {l_log[0][7:0], l_log[1][7:0], l_log[2][7:0]}, {8'd15, 8'd15, 8'd7});
        chk("w40_nlast", last_log.size(), 3);
        chk("w40_lasts", {last_log[0][7:0], last_log[1][7:0], last_log[2][7:0]}, {8'd15, 8'd31, 8'd39});
        chk("w40_b_seen", b_lat < 20, 1);
        chk("w40_b_extra", nb, 0);
        chk("w40_b_id", b_id_seen, 1);
        chk("w40_b_resp", b_resp_seen, 2'd0);
        chk("w40_w_early", early_wr, 0);

        read_burst(16'h1000, 8'd39);
        chk("r40_nsub", a_log.size(), 3);
        chk("r40_addrs", {a_log[0], a_log[1], a_log[2]}, {16'h1000, 16'h1040, 16'h1080});
        chk("r40_lens", {l_log[0][7:0], l_log[1][7:0], l_log[2][7:0]}, {8'd15, 8'd15, 8'd7});
        chk("r40_beats", nbeats, 40);
        chk("r40_nlast", last_log.size(), 1);
        chk("r40_last_pos", last_log[0], 39);
        chk("r40_data", rbad, 0);

        write_burst(16'h0104, 2'b01, 8'd3, 2'd0, 2'd0);
        chk("w4_nsub", a_log.size(), 1);
        chk("w4_aw", {a_log[0], l_log[0][7:0]}, {16'h0104, 8'd3});
        chk("w4_attr", aw_attr, {3'd2, 2'b01, 4'h3, 1'b1});
        chk("w4_last", last_log[0], 3);
        chk("w4_b_lat", b_lat, 0);

        write_burst(16'h2000, 2'b01, 8'd31, 2'd2, 2'd0);
        chk("w32_nsub", a_log.size(), 2);
`ifdef NASTI_BURST_SPLIT_RESP_MERGE_EN
        chk("w32_b_resp", b_resp_seen, 2'd2);
`else
        chk("w32_b_resp", b_resp_seen, 2'd0);
`endif
        chk("w32_b_user", b_user_seen, 1);

        write_burst(16'h0020, 2'b00, 8'd20, 2'd0, 2'd0);
        chk("fix_nsub", a_log.size(), 2);
        chk("fix_aw", {a_log[0], l_log[0][7:0], a_log[1], l_log[1][7:0]}, {16'h0020, 8'd15, 16'h0020, 8'd4});

        // Leave a B and an R beat pending with upstream stalled, then reset mid-burst.
        s_bus.aw_id = 1'b0; s_bus.aw_addr = 16'h0200; s_bus.aw_len = 8'd3; s_bus.aw_burst = 2'b01; s_bus.aw_valid = 1'b1;
        tick;
        s_bus.aw_valid = 1'b0;
        g = 0; while (!m_bus.aw_valid && g < 20) begin tick; g++; end
        m_bus.aw_ready = 1'b1;
        tick;
        m_bus.aw_ready = 1'b0; s_bus.w_valid = 1'b1; m_bus.w_ready = 1'b1;
        repeat (4) tick;
        s_bus.w_valid = 1'b0; m_bus.w_ready = 1'b0; m_bus.b_valid = 1'b1;
        tick;
        m_bus.b_valid = 1'b0;
        s_bus.ar_addr = 16'h0300; s_bus.ar_len = 8'd39; s_bus.ar_burst = 2'b01; s_bus.ar_valid = 1'b1;
        tick;
        s_bus.ar_valid = 1'b0;
        g = 0; while (!m_bus.ar_valid && g < 20) begin tick; g++; end
        m_bus.ar_ready = 1'b1;
        tick;
        m_bus.ar_ready = 1'b0; m_bus.r_valid = 1'b1;
        repeat (10) tick;
        chk("stall_pending", {s_bus.b_valid, s_bus.r_valid}, 2'b11);
        #2 rstn = 1'b0;
        #1 chk("rst_during", {m_bus.aw_valid, m_bus.ar_valid, m_bus.w_valid, s_bus.b_valid, s_bus.r_valid}, 0);
        tick;
        init_bus;
        rstn = 1'b1;
        tick;
        chk("rst_after", {m_bus.aw_valid, m_bus.ar_valid, m_bus.w_valid, s_bus.b_valid, s_bus.r_valid}, 0);

        write_burst(16'h0400, 2'b01, 8'd3, 2'd0, 2'd0);
        chk("post_rst_aw", {a_log.size() == 1, a_log[0], l_log[0][7:0]}, {1'b1, 16'h0400, 8'd3});
        chk("post_rst_b", {b_lat < 20, b_resp_seen, nb == 0}, {1'b1, 2'd0, 1'b1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
